// File: rtl/jtdd_prom_we_ctrl.sv
// ROM download router for Double Dragon: turns the ioctl byte stream into
// SDRAM byte-lane writes (linear and plane-interleaved regions) and one-hot BRAM strobes.
module jtdd_prom_we_ctrl #(
  parameter logic [21:0] BANK_ADDR  = 22'h00000,
  parameter logic [21:0] MAIN_ADDR  = 22'h20000,
  parameter logic [21:0] SND_ADDR   = 22'h28000,
  parameter logic [21:0] ADPCM_0    = 22'h30000,
  parameter logic [21:0] ADPCM_1    = 22'h40000,
  parameter logic [21:0] CHAR_ADDR  = 22'h50000,
  parameter logic [21:0] SCRZW_ADDR = 22'h60000,
  parameter logic [21:0] SCRXY_ADDR = 22'h80000,
  parameter logic [21:0] OBJWZ_ADDR = 22'hA0000,
  parameter logic [21:0] OBJXY_ADDR = 22'hE0000,
  parameter logic [21:0] MCU_ADDR   = 22'h120000,
  parameter logic [21:0] PROM_ADDR  = 22'h124000,
  parameter int          PROM_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [21:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [21:0]       prog_addr,
  output logic [7:0]        prog_data,
  output logic [1:0]        prog_mask,
  output logic              prog_we,
  output logic [PROM_W-1:0] prom_we
);

  // A misordered linear layout blanks the linear ROMs instead of scrambling them.
  localparam logic LAYOUT_OK = (BANK_ADDR <= MAIN_ADDR) && (MAIN_ADDR <= SND_ADDR) &&
                               (SND_ADDR <= ADPCM_0) && (ADPCM_0 <= ADPCM_1) &&
                               (ADPCM_1 <= CHAR_ADDR) && (CHAR_ADDR <= SCRZW_ADDR);
  localparam logic [21:0] SCR_BASE = SCRZW_ADDR >> 1;
  localparam logic [21:0] OBJ_BASE = OBJWZ_ADDR >> 1;
  localparam logic [21:0] PROM_N   = 22'(PROM_W);

  logic              accept, upd, we_nxt;
  logic [21:0]       a, prom_off, prom_k, addr_nxt;
  logic [1:0]        mask_nxt;
  logic [PROM_W-1:0] prom_nxt;

  assign a        = ioctl_addr;
  assign accept   = ioctl_wr && downloading;
  assign prom_off = a - PROM_ADDR;
  assign prom_k   = (prom_off >> 8) + 22'd1;

  always_comb begin
    upd      = 1'b0;
    we_nxt   = 1'b0;
    prom_nxt = '0;
    addr_nxt = '0;
    mask_nxt = 2'b11;
    if (accept) begin
      if (a < SCRZW_ADDR) begin
        upd      = LAYOUT_OK;
        we_nxt   = LAYOUT_OK;
        addr_nxt = a >> 1;
        mask_nxt = a[0] ? 2'b01 : 2'b10;
      end else if (a < OBJWZ_ADDR) begin
        upd    = 1'b1;
        we_nxt = 1'b1;
        if (a < SCRXY_ADDR) begin
          addr_nxt = SCR_BASE + (a - SCRZW_ADDR);
          mask_nxt = 2'b10;
        end else begin
          addr_nxt = SCR_BASE + (a - SCRXY_ADDR);
          mask_nxt = 2'b01;
        end
      end else if (a < MCU_ADDR) begin
        upd    = 1'b1;
        we_nxt = 1'b1;
        if (a < OBJXY_ADDR) begin
          addr_nxt = OBJ_BASE + (a - OBJWZ_ADDR);
          mask_nxt = 2'b10;
        end else begin
          addr_nxt = OBJ_BASE + (a - OBJXY_ADDR);
          mask_nxt = 2'b01;
        end
      end else if (a < PROM_ADDR) begin
        upd         = 1'b1;
        addr_nxt    = a - MCU_ADDR;
        prom_nxt[0] = 1'b1;
      end else if (prom_k < PROM_N) begin
        // bytes past the last PROM fall through with no strobe
        upd      = 1'b1;
        addr_nxt = {14'd0, prom_off[7:0]};
        for (int i = 1; i < PROM_W; i++) prom_nxt[i] = (prom_k == 22'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_addr <= '0;
      prog_data <= '0;
      prog_mask <= 2'b11;
      prog_we   <= 1'b0;
      prom_we   <= '0;
    end else begin
      prog_we <= we_nxt;
      prom_we <= prom_nxt;
      if (upd) begin
        prog_addr <= addr_nxt;
        prog_data <= ioctl_data;
        prog_mask <= mask_nxt;
      end
    end
  end

endmodule

// File: tb/tb_jtdd_prom_we_ctrl.sv
// Directed bench for jtdd_prom_we_ctrl with DD1 layout and a small SDRAM lane model.
module tb_jtdd_prom_we_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, downloading, ioctl_wr;
  logic [21:0] ioctl_addr, prog_addr;
  logic [7:0]  ioctl_data, prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [3:0]  prom_we;

  int passed = 0;
  int total  = 0;
  int we_falls = 0;
  int onehot_bad = 0;
  logic [15:0] mem [logic [21:0]];

  jtdd_prom_we_ctrl dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
    .prog_we(prog_we), .prom_we(prom_we)
  );

  always #5 clk = ~clk;

  // SDRAM model: lanes latched on the strobe's falling edge
  always @(negedge prog_we) begin
    if (rst_n === 1'b1) begin
      we_falls++;
      if (!mem.exists(prog_addr)) mem[prog_addr] = 16'h0000;
      if (!prog_mask[0]) mem[prog_addr][7:0]  = prog_data;
      if (!prog_mask[1]) mem[prog_addr][15:8] = prog_data;
    end
  end

  always @(negedge clk)
    if (rst_n === 1'b1 && ($countones(prom_we) + int'(prog_we)) > 1) onehot_bad++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // drive one byte; returns at the negedge where the strobe is visible
  task automatic send(input logic [21:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic chk_sd(input string tag, input logic [21:0] ad, input logic [7:0] d, input logic [1:0] m);
    chk({tag, "_we"},   32'(prog_we), 32'd1);
    chk({tag, "_addr"}, 32'(prog_addr), 32'(ad));
    chk({tag, "_data"}, 32'(prog_data), 32'(d));
    chk({tag, "_mask"}, 32'(prog_mask), 32'(m));
    chk({tag, "_prom"}, 32'(prom_we), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"},   32'(prog_we), 32'd0);
    chk({tag, "_addr"}, 32'(prog_addr), 32'd0);
    chk({tag, "_data"}, 32'(prog_data), 32'd0);
    chk({tag, "_mask"}, 32'(prog_mask), 32'd3);
    chk({tag, "_prom"}, 32'(prom_we), 32'd0);
  endtask

  logic [21:0] s_addr [12] = '{22'h00002, 22'h00003, 22'h28011, 22'h5FFFF,
                               22'h60000, 22'h7FFFF, 22'h80000, 22'h9FFFF,
                               22'hA0000, 22'hDFFFF, 22'hE0000, 22'h11FFFF};
  logic [21:0] s_word [12] = '{22'h00001, 22'h00001, 22'h14008, 22'h2FFFF,
                               22'h30000, 22'h4FFFF, 22'h30000, 22'h4FFFF,
                               22'h50000, 22'h8FFFF, 22'h50000, 22'h8FFFF};
  logic        s_up   [12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0; downloading = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_data = '0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1; downloading = 1'b1;

    // linear region, even then odd byte
    send(22'h00000, 8'h12);
    chk_sd("lin_even", 22'h0, 8'h12, 2'b10);
    @(negedge clk);
    chk("lin_even_pulse_end", 32'(prog_we), 32'd0);
    chk("lin_even_hold_addr", 32'(prog_addr), 32'h0);
    chk("lin_even_hold_data", 32'(prog_data), 32'h12);
    send(22'h00001, 8'h34);
    chk_sd("lin_odd", 22'h0, 8'h34, 2'b01);
    @(negedge clk);
    chk("lin_odd_pulse_end", 32'(prog_we), 32'd0);

    // scroll and object interleave
    send(22'h60005, 8'hAA);
    chk_sd("scr_zw", 22'h30005, 8'hAA, 2'b10);
    send(22'h80005, 8'hBB);
    chk_sd("scr_xy", 22'h30005, 8'hBB, 2'b01);
    send(22'hE0010, 8'h5C);
    chk_sd("obj_xy", 22'h50010, 8'h5C, 2'b01);
    @(negedge clk);
    chk("obj_pulse_end", 32'(prog_we), 32'd0);

    // MCU and PROM BRAM strobes
    send(22'h120003, 8'h61);
    chk("mcu_prom", 32'(prom_we), 32'b0001);
    chk("mcu_addr", 32'(prog_addr), 32'd3);
    chk("mcu_data", 32'(prog_data), 32'h61);
    chk("mcu_no_we", 32'(prog_we), 32'd0);
    @(negedge clk);
    chk("mcu_pulse_end", 32'(prom_we), 32'd0);
    send(22'h124000, 8'h62);
    chk("prom1_prom", 32'(prom_we), 32'b0010);
    chk("prom1_addr", 32'(prog_addr), 32'd0);
    send(22'h124201, 8'h63);
    chk("prom3_prom", 32'(prom_we), 32'b1000);
    chk("prom3_addr", 32'(prog_addr), 32'd1);
    chk("prom3_no_we", 32'(prog_we), 32'd0);
    send(22'h124300, 8'h64);
    chk("prom_drop_prom", 32'(prom_we), 32'd0);
    chk("prom_drop_we", 32'(prog_we), 32'd0);

    // back-to-back bytes keep the strobe high
    @(negedge clk);
    ioctl_addr = 22'h00004; ioctl_data = 8'h77; ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_addr = 22'h00005; ioctl_data = 8'h88;
    chk_sd("b2b_first", 22'h2, 8'h77, 2'b10);
    @(negedge clk);
    ioctl_wr = 1'b0;
    chk_sd("b2b_second", 22'h2, 8'h88, 2'b01);
    @(negedge clk);
    chk("b2b_end", 32'(prog_we), 32'd0);

    // downloading low: strobe in flight completes, new bytes ignored
    send(22'h00006, 8'h44);
    downloading = 1'b0;
    chk("dl_inflight_we", 32'(prog_we), 32'd1);
    @(negedge clk);
    chk("dl_inflight_end", 32'(prog_we), 32'd0);
    send(22'h00010, 8'h99);
    chk("dl_off_we", 32'(prog_we), 32'd0);
    chk("dl_off_prom", 32'(prom_we), 32'd0);
    chk("dl_off_data", 32'(prog_data), 32'h44);
    send(22'h120001, 8'h9A);
    chk("dl_off_mcu", 32'(prom_we), 32'd0);
    downloading = 1'b1;

    // sampled image streamed at one byte per 4 cycles into the SDRAM model
    mem.delete();
    we_falls = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ioctl_addr = s_addr[i]; ioctl_data = 8'(8'h30 + i * 7); ioctl_wr = 1'b1;
      @(negedge clk);
      ioctl_wr = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("stream_pulses", 32'(we_falls), 32'd12);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] w;
      logic [7:0]  b;
      w = mem.exists(s_word[i]) ? mem[s_word[i]] : 16'hxxxx;
      b = s_up[i] ? w[15:8] : w[7:0];
      chk($sformatf("stream_%0d", i), 32'(b), 32'(8'(8'h30 + i * 7)));
    end

    // reset in the middle of a strobe
    send(22'h00020, 8'h55);
    chk("rst_pre_we", 32'(prog_we), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid");
    send(22'h00022, 8'h56);
    chk_reset("rst_held");
    rst_n = 1'b1;
    @(negedge clk);
    chk("onehot", 32'(onehot_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
